// File: rtl/alu_rr_sequencer.sv
// rtl/alu_rr_sequencer.sv - round-robin sharing of one registered-pin ALU between two requesters
// One command in flight: IDLE accepts, WAIT counts ALU latency, RESP holds the tagged result.
module alu_rr_sequencer #(
  parameter int WIDTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_sel,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_sel,
  input  logic             req1_cin,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_s2,
  output logic             alu_s1,
  output logic             alu_s0,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_word_out,
  input  logic             alu_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_word,
  output logic             rsp_cout,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;

  localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_sel_q, alu_sel_d;
  logic             alu_cin_q, alu_cin_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_word_q, rsp_word_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             grant0, grant1;

  // prio names the favoured requester; a lone valid requester always wins.
  assign grant0     = req0_valid & (~prio_q | ~req1_valid);
  assign grant1     = req1_valid & (prio_q | ~req0_valid);
  assign req0_ready = (state_q == IDLE) & grant0;
  assign req1_ready = (state_q == IDLE) & grant1;

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    alu_cin_d   = alu_cin_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_word_d  = rsp_word_q;
    rsp_cout_d  = rsp_cout_q;
    case (state_q)
      IDLE: begin
        if (grant0 | grant1) begin
          alu_a_d   = grant1 ? req1_a   : req0_a;
          alu_b_d   = grant1 ? req1_b   : req0_b;
          alu_sel_d = grant1 ? req1_sel : req0_sel;
          alu_cin_d = grant1 ? req1_cin : req0_cin;
          rsp_id_d  = grant1;
          prio_d    = ~grant1;
          cnt_d     = CNT_INIT;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          rsp_word_d  = alu_word_out;
          rsp_cout_d  = alu_cout;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      cnt_q       <= 4'd0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= 3'd0;
      alu_cin_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_word_q  <= '0;
      rsp_cout_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      alu_cin_q   <= alu_cin_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_word_q  <= rsp_word_d;
      rsp_cout_q  <= rsp_cout_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_s2    = alu_sel_q[2];
  assign alu_s1    = alu_sel_q[1];
  assign alu_s0    = alu_sel_q[0];
  assign alu_cin   = alu_cin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_word  = rsp_word_q;
  assign rsp_cout  = rsp_cout_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// tb/tb_alu_rr_sequencer.sv - self-checking bench for alu_rr_sequencer
// d0 runs ALU_LAT=1 against an adder-style ALU; d1 runs ALU_LAT=3 against a time-varying ALU.
module tb_alu_rr_sequencer;
  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  logic         rst0_n, rst1_n;
  logic         req0_valid, req1_valid, req0_cin, req1_cin, rsp_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_sel, req1_sel;

  logic         d0_req0_ready, d0_req1_ready, d0_s2, d0_s1, d0_s0, d0_cin;
  logic         d0_rsp_valid, d0_rsp_id, d0_rsp_cout, d0_busy, d0_alu_cout;
  logic [W-1:0] d0_alu_a, d0_alu_b, d0_rsp_word, d0_alu_word;
  logic         d1_req0_ready, d1_req1_ready, d1_s2, d1_s1, d1_s0, d1_cin;
  logic         d1_rsp_valid, d1_rsp_id, d1_rsp_cout, d1_busy, d1_alu_cout;
  logic [W-1:0] d1_alu_a, d1_alu_b, d1_rsp_word, d1_alu_word;

  assign d0_alu_word = W'(d0_alu_a + d0_alu_b + W'({d0_s2, d0_s1, d0_s0}));
  assign d0_alu_cout = d0_cin;
  assign d1_alu_word = d1_alu_a ^ cyc[3:0];
  assign d1_alu_cout = cyc[4];

  alu_rr_sequencer #(.WIDTH(W), .ALU_LAT(1)) d0 (
    .clk(clk), .rst_n(rst0_n),
    .req0_valid(req0_valid), .req0_ready(d0_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sel(req0_sel), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(d0_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sel(req1_sel), .req1_cin(req1_cin),
    .alu_a(d0_alu_a), .alu_b(d0_alu_b), .alu_s2(d0_s2), .alu_s1(d0_s1), .alu_s0(d0_s0),
    .alu_cin(d0_cin), .alu_word_out(d0_alu_word), .alu_cout(d0_alu_cout),
    .rsp_valid(d0_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(d0_rsp_id),
    .rsp_word(d0_rsp_word), .rsp_cout(d0_rsp_cout), .busy(d0_busy)
  );

  alu_rr_sequencer #(.WIDTH(W), .ALU_LAT(3)) d1 (
    .clk(clk), .rst_n(rst1_n),
    .req0_valid(req0_valid), .req0_ready(d1_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sel(req0_sel), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(d1_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sel(req1_sel), .req1_cin(req1_cin),
    .alu_a(d1_alu_a), .alu_b(d1_alu_b), .alu_s2(d1_s2), .alu_s1(d1_s1), .alu_s0(d1_s0),
    .alu_cin(d1_cin), .alu_word_out(d1_alu_word), .alu_cout(d1_alu_cout),
    .rsp_valid(d1_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(d1_rsp_id),
    .rsp_word(d1_rsp_word), .rsp_cout(d1_rsp_cout), .busy(d1_busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
    return 4'(a + b + {1'b0, s});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_d0_zero(input string tag);
    chk({tag, "_ready"}, {30'd0, d0_req0_ready, d0_req1_ready}, 32'd0);
    chk({tag, "_busy"}, {31'd0, d0_busy}, 32'd0);
    chk({tag, "_alu"}, {20'd0, d0_alu_a, d0_alu_b, d0_s2, d0_s1, d0_s0, d0_cin}, 32'd0);
    chk({tag, "_rsp"}, {25'd0, d0_rsp_valid, d0_rsp_id, d0_rsp_word, d0_rsp_cout}, 32'd0);
  endtask

  int           acc_id[$];
  int           acc_cyc[$];
  int           rid[$];
  logic [3:0]   rw[$];
  int           k;
  logic [31:0]  c0, e;
  logic         v0, v1, w, last_w;
  logic [3:0]   ref_word, hold_word;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst0_n = 1'b0; rst1_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req0_sel = 3'd0; req0_cin = 1'b0;
    req1_a = '0; req1_b = '0; req1_sel = 3'd0; req1_cin = 1'b0;
    repeat (2) tick();
    chk_d0_zero("reset");
    rst0_n = 1'b1;
    tick();

    // Directed: single req0 command, ALU returns A/1.
    req0_a = 4'd3; req0_b = 4'd5; req0_sel = 3'b010; req0_cin = 1'b1; req0_valid = 1'b1;
    #1;
    chk("t2_ready", {30'd0, d0_req0_ready, d0_req1_ready}, 32'b10);
    c0 = cyc;
    tick();
    req0_valid = 1'b0;
    chk("t2_alu", {20'd0, d0_alu_a, d0_alu_b, d0_s2, d0_s1, d0_s0, d0_cin}, {20'd0, 4'd3, 4'd5, 3'b010, 1'b1});
    chk("t2_busy", {31'd0, d0_busy}, 32'd1);
    chk("t2_rsp_early", {31'd0, d0_rsp_valid}, 32'd0);
    tick();
    chk("t2_lat", cyc - c0, 32'd2);
    chk("t2_rsp", {25'd0, d0_rsp_valid, d0_rsp_id, d0_rsp_word, d0_rsp_cout}, {25'd0, 1'b1, 1'b0, 4'hA, 1'b1});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t2_done", {30'd0, d0_rsp_valid, d0_busy}, 32'd0);

    // Back-pressure on the response.
    req1_a = 4'd9; req1_b = 4'd6; req1_sel = 3'd7; req1_cin = 1'b0; req1_valid = 1'b1;
    #1;
    chk("t4_ready", {30'd0, d0_req0_ready, d0_req1_ready}, 32'b01);
    tick();
    req1_valid = 1'b0;
    tick();
    hold_word = alu_ref(4'd9, 4'd6, 3'd7);
    chk("t4_rsp", {25'd0, d0_rsp_valid, d0_rsp_id, d0_rsp_word, d0_rsp_cout}, {25'd0, 1'b1, 1'b1, hold_word, 1'b0});
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_hold_rsp", {25'd0, d0_rsp_valid, d0_rsp_id, d0_rsp_word, d0_rsp_cout}, {25'd0, 1'b1, 1'b1, hold_word, 1'b0});
      chk("t4_hold_rdy", {29'd0, d0_req0_ready, d0_req1_ready, d0_busy}, 32'b001);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("t4_release", {30'd0, d0_rsp_valid, d0_req0_ready}, 32'b01);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Both requesters streaming with rsp_ready high.
    req0_a = 4'd1; req0_b = 4'd2; req0_sel = 3'd0; req0_cin = 1'b0;
    req1_a = 4'd7; req1_b = 4'd4; req1_sel = 3'd5; req1_cin = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 40 && rid.size() < 4; i++) begin
      #1;
      if (d0_req0_ready) begin acc_id.push_back(0); acc_cyc.push_back(int'(cyc)); end
      if (d0_req1_ready) begin acc_id.push_back(1); acc_cyc.push_back(int'(cyc)); end
      if (d0_rsp_valid) begin rid.push_back(int'(d0_rsp_id)); rw.push_back(d0_rsp_word); end
      tick();
      if (acc_id.size() >= 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    end
    rsp_ready = 1'b0;
    chk("t3_n_acc", acc_id.size(), 32'd4);
    chk("t3_n_rsp", rid.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (acc_id.size() > i) chk("t3_acc_id", acc_id[i], i % 2);
      if (rid.size() > i) begin
        chk("t3_rsp_id", rid[i], i % 2);
        chk("t3_rsp_word", {28'd0, rw[i]}, {28'd0, (i % 2 == 1) ? alu_ref(4'd7, 4'd4, 3'd5) : alu_ref(4'd1, 4'd2, 3'd0)});
      end
      if (i > 0 && acc_cyc.size() > i) chk("t3_spacing", acc_cyc[i] - acc_cyc[i-1], 32'd3);
    end

    // Asynchronous reset while a command is in WAIT.
    req1_a = 4'd5; req1_b = 4'd5; req1_sel = 3'd1; req1_cin = 1'b1; req1_valid = 1'b1;
    #1;
    chk("t5_ready", {30'd0, d0_req0_ready, d0_req1_ready}, 32'b01);
    tick();
    req1_valid = 1'b0;
    chk("t5_in_wait", {30'd0, d0_busy, d0_rsp_valid}, 32'b10);
    rst0_n = 1'b0;
    #1;
    chk_d0_zero("t1_async");
    #1;
    rst0_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_rsp", {30'd0, d0_rsp_valid, d0_busy}, 32'd0);
    end
    req1_a = 4'd2; req1_b = 4'd3; req1_sel = 3'd4; req1_cin = 1'b0; req1_valid = 1'b1;
    #1;
    chk("t5_req1_ready", {30'd0, d0_req0_ready, d0_req1_ready}, 32'b01);
    tick();
    req1_valid = 1'b0;
    chk("t5_alu", {20'd0, d0_alu_a, d0_alu_b, d0_s2, d0_s1, d0_s0, d0_cin}, {20'd0, 4'd2, 4'd3, 3'd4, 1'b0});
    tick();
    chk("t5_rsp", {25'd0, d0_rsp_valid, d0_rsp_id, d0_rsp_word, d0_rsp_cout}, {25'd0, 1'b1, 1'b1, alu_ref(4'd2, 4'd3, 3'd4), 1'b0});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t5_done", {31'd0, d0_rsp_valid}, 32'd0);

    // Randomized traffic against a round-robin reference.
    last_w = 1'b1;
    for (int t = 0; t < 30; t++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      req0_a = 4'($urandom); req0_b = 4'($urandom); req0_sel = 3'($urandom); req0_cin = 1'($urandom);
      req1_a = 4'($urandom); req1_b = 4'($urandom); req1_sel = 3'($urandom); req1_cin = 1'($urandom);
      req0_valid = v0; req1_valid = v1;
      #1;
      w = (v0 && v1) ? ~last_w : v1;
      chk("rnd_ready", {30'd0, d0_req0_ready, d0_req1_ready}, {30'd0, ~w, w});
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      last_w = w;
      chk("rnd_alu", {20'd0, d0_alu_a, d0_alu_b, d0_s2, d0_s1, d0_s0, d0_cin},
          w ? {20'd0, req1_a, req1_b, req1_sel, req1_cin} : {20'd0, req0_a, req0_b, req0_sel, req0_cin});
      tick();
      ref_word = w ? alu_ref(req1_a, req1_b, req1_sel) : alu_ref(req0_a, req0_b, req0_sel);
      chk("rnd_rsp", {25'd0, d0_rsp_valid, d0_rsp_id, d0_rsp_word, d0_rsp_cout},
          {25'd0, 1'b1, w, ref_word, w ? req1_cin : req0_cin});
      k = int'($urandom_range(0, 3));
      for (int j = 0; j < k; j++) begin
        req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
        #1;
        chk("rnd_hold", {29'd0, d0_req0_ready, d0_req1_ready, d0_rsp_valid}, 32'b001);
        tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("rnd_done", {30'd0, d0_rsp_valid, d0_busy}, 32'd0);
    end

    // ALU_LAT=3 instance: latency and capture point.
    rst0_n = 1'b0; rst1_n = 1'b1;
    tick();
    req0_a = 4'($urandom); req0_valid = 1'b1; req1_valid = 1'b0;
    #1;
    chk("t6_ready", {30'd0, d1_req0_ready, d1_req1_ready}, 32'b10);
    c0 = cyc;
    tick();
    req0_valid = 1'b0;
    chk("t6_alu_a", {28'd0, d1_alu_a}, {28'd0, req0_a});
    k = 1;
    while (!d1_rsp_valid && k < 12) begin
      tick();
      k++;
    end
    chk("t6_lat", k, 32'd4);
    e = c0 + 32'd3;
    chk("t6_rsp", {26'd0, d1_rsp_id, d1_rsp_word, d1_rsp_cout}, {26'd0, 1'b0, req0_a ^ e[3:0], e[4]});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t6_done", {30'd0, d1_rsp_valid, d1_busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
